// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_pkg
// Description : Shared definitions for the MEM stage / MEM-WB register:
//               FSM state encoding, default widths, zero-register constant.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    // Register index 0 is hard-wired; writes to it are suppressed.
    localparam logic [REG_W_DEF-1:0] REG_ZERO = '0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mem_state_e;

endpackage : mem_wb_stage_pkg
`default_nettype wire

// File: rtl/mem_req_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_timer
// Description : Saturating cycle counter used to bound an outstanding data
//               memory request. Cleared while idle, counts while waiting.
// Ports       : clk, rst_n   - clock / async active-low reset
//               clr_i        - force count to zero (has priority)
//               en_i         - advance count by one (saturates)
//               expired_o    - count has reached TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int              CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != C_LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == C_LAST);

endmodule : mem_req_timer
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM stage plus MEM/WB pipeline register. Issues word loads
//               and stores to data memory over a req/ack handshake, stalls
//               upstream while an access is outstanding, aborts with a
//               one-cycle error pulse on misalignment or timeout, and
//               presents the registered write-back triple.
// Ports       : clk, rst_n                      - clock / async reset
//               ex_valid .. reg_wr              - EX/MEM register contents
//               stall_o                         - hold EX/MEM
//               dmem_req/we/addr/wdata, ack/rdata - data memory port
//               wb_valid/we/addr/data           - MEM/WB register
//               mem_error                       - abort pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rt,
    input  logic [DATA_W-1:0] store_data,
    input  logic              wb_sel,
    input  logic              dst_sel,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              reg_wr,
    output logic              stall_o,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_error
);

    // ------------------------------------------------------------------
    // Decode of the incoming EX/MEM slot
    // ------------------------------------------------------------------
    logic             w_mem_op;
    logic             w_misaligned;
    logic             w_start;
    logic [REG_W-1:0] w_dst;
    logic             w_dst_we;
    logic             w_expired;
    logic             w_stall;

    assign w_mem_op     = mem_rd | mem_wr;
    assign w_misaligned = |alu_res[1:0];
    assign w_start      = ex_valid & w_mem_op & ~w_misaligned;
    assign w_dst        = dst_sel ? rd : rt;
    assign w_dst_we     = reg_wr && (w_dst != REG_W'(REG_ZERO));

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    mem_state_e        state_q, state_d;

    logic              dmem_req_q,   dmem_req_d;
    logic              dmem_we_q,    dmem_we_d;
    logic [DATA_W-1:0] dmem_addr_q,  dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;

    // Holding registers for the write-back half of an outstanding load.
    logic [REG_W-1:0]  hold_dst_q,    hold_dst_d;
    logic              hold_wb_sel_q, hold_wb_sel_d;
    logic              hold_we_q,     hold_we_d;

    logic              wb_valid_q,  wb_valid_d;
    logic              wb_we_q,     wb_we_d;
    logic [REG_W-1:0]  wb_addr_q,   wb_addr_d;
    logic [DATA_W-1:0] wb_data_q,   wb_data_d;
    logic              mem_error_q, mem_error_d;

    // ------------------------------------------------------------------
    // Timeout timer: held at zero while idle so it starts fresh on REQ
    // entry; only advances on cycles without an acknowledge.
    // ------------------------------------------------------------------
    mem_req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == ST_IDLE),
        .en_i      ((state_q == ST_REQ) && !dmem_ack),
        .expired_o (w_expired)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Acknowledge wins over a coincident timeout.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_start)                 state_d = ST_REQ;
            ST_REQ:  if (dmem_ack || w_expired)   state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_stall       = 1'b0;
        dmem_req_d    = dmem_req_q;
        dmem_we_d     = dmem_we_q;
        dmem_addr_d   = dmem_addr_q;
        dmem_wdata_d  = dmem_wdata_q;
        hold_dst_d    = hold_dst_q;
        hold_wb_sel_d = hold_wb_sel_q;
        hold_we_d     = hold_we_q;
        wb_valid_d    = wb_valid_q;
        wb_we_d       = wb_we_q;
        wb_addr_d     = wb_addr_q;
        wb_data_d     = wb_data_q;
        mem_error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_stall = w_start;
                if (!ex_valid) begin
                    wb_valid_d = 1'b0;
                    wb_we_d    = 1'b0;
                end else if (!w_mem_op) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = w_dst_we;
                    wb_addr_d  = w_dst;
                    wb_data_d  = alu_res;
                end else if (w_misaligned) begin
                    mem_error_d = 1'b1;
                    wb_valid_d  = 1'b1;
                    wb_we_d     = 1'b0;
                    wb_addr_d   = w_dst;
                end else begin
                    dmem_req_d    = 1'b1;
                    dmem_we_d     = mem_wr;
                    dmem_addr_d   = {alu_res[DATA_W-1:2], 2'b00};
                    dmem_wdata_d  = store_data;
                    hold_dst_d    = w_dst;
                    hold_wb_sel_d = wb_sel;
                    // mem_rd together with mem_wr behaves as a store.
                    hold_we_d     = w_dst_we && !mem_wr;
                    wb_valid_d    = 1'b0;
                    wb_we_d       = 1'b0;
                end
            end

            ST_REQ: begin
                // Stall stays high through an abort cycle; upstream
                // retires the op as a bubble on the following cycle.
                w_stall = !dmem_ack;
                if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_addr_d  = hold_dst_q;
                    if (dmem_we_q) begin
                        wb_we_d = 1'b0;
                    end else begin
                        wb_we_d   = hold_we_q;
                        wb_data_d = hold_wb_sel_q ? dmem_rdata : dmem_addr_q;
                    end
                end else if (w_expired) begin
                    dmem_req_d  = 1'b0;
                    mem_error_d = 1'b1;
                    wb_valid_d  = 1'b1;
                    wb_we_d     = 1'b0;
                end else begin
                    wb_valid_d = 1'b0;
                    wb_we_d    = 1'b0;
                end
            end

            default: begin
                w_stall = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_wdata_q  <= '0;
            hold_dst_q    <= '0;
            hold_wb_sel_q <= 1'b0;
            hold_we_q     <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_addr_q     <= '0;
            wb_data_q     <= '0;
            mem_error_q   <= 1'b0;
        end else begin
            dmem_req_q    <= dmem_req_d;
            dmem_we_q     <= dmem_we_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_wdata_q  <= dmem_wdata_d;
            hold_dst_q    <= hold_dst_d;
            hold_wb_sel_q <= hold_wb_sel_d;
            hold_we_q     <= hold_we_d;
            wb_valid_q    <= wb_valid_d;
            wb_we_q       <= wb_we_d;
            wb_addr_q     <= wb_addr_d;
            wb_data_q     <= wb_data_d;
            mem_error_q   <= mem_error_d;
        end
    end

    // Stall is gated by reset so it falls with the rest of the outputs
    // even while upstream still presents a memory op.
    assign stall_o    = rst_n & w_stall;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign mem_error  = mem_error_q;

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage. Each operation is
//               issued as a transaction; expected handshake length, stall
//               behaviour and write-back triple come from a transaction
//               level model of the stage's rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int C_TIMEOUT = 16;
    localparam int C_NEVER   = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] alu_res;
    logic [4:0]  rd, rt;
    logic [31:0] store_data;
    logic        wb_sel, dst_sel, mem_rd, mem_wr, reg_wr;
    logic        stall_o;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mem_error;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_W  (32),
        .REG_W   (5),
        .TIMEOUT (C_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .alu_res    (alu_res),
        .rd         (rd),
        .rt         (rt),
        .store_data (store_data),
        .wb_sel     (wb_sel),
        .dst_sel    (dst_sel),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .reg_wr     (reg_wr),
        .stall_o    (stall_o),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .mem_error  (mem_error)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one EX/MEM op and follow it to write-back, then insert a bubble.
    // ack_dly: number of REQ cycles before the ack cycle (>= TIMEOUT: none).
    task automatic run_op(input logic [31:0] a, input logic [4:0] f_rd, input logic [4:0] f_rt,
                          input logic [31:0] sd, input logic f_wbsel, input logic f_dstsel,
                          input logic f_mrd, input logic f_mwr, input logic f_regwr,
                          input int ack_dly, input logic [31:0] rdata);
        logic        memop, mis, store, tmo;
        logic [4:0]  dst;
        logic [31:0] aligned;
        int          nreq;
        bit          done;

        memop   = f_mrd | f_mwr;
        mis     = memop && (a[1:0] != 2'b00);
        store   = f_mwr;
        dst     = f_dstsel ? f_rd : f_rt;
        aligned = a & 32'hFFFF_FFFC;
        tmo     = (ack_dly >= C_TIMEOUT);

        ex_valid = 1'b1; alu_res = a; rd = f_rd; rt = f_rt; store_data = sd;
        wb_sel = f_wbsel; dst_sel = f_dstsel; mem_rd = f_mrd; mem_wr = f_mwr; reg_wr = f_regwr;
        // An ack seen while idle must have no effect.
        dmem_ack   = memop ? 1'b0 : 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #1;
        check_eq("stall_accept", 32'(stall_o), 32'(memop && !mis));

        if (!memop || mis) begin
            tick();
            check_eq("wb_valid", 32'(wb_valid), 32'd1);
            check_eq("wb_we", 32'(wb_we), 32'(!mis && f_regwr && dst != 5'd0));
            check_eq("mem_error", 32'(mem_error), 32'(mis));
            check_eq("no_req", 32'(dmem_req), 32'd0);
            if (!mis) begin
                check_eq("wb_addr", 32'(wb_addr), 32'(dst));
                check_eq("wb_data_alu", wb_data, a);
            end
        end else begin
            dmem_ack = 1'b0;
            tick();
            check_eq("dmem_addr", dmem_addr, aligned);
            check_eq("dmem_we", 32'(dmem_we), 32'(store));
            if (store) check_eq("dmem_wdata", dmem_wdata, sd);
            nreq = 0;
            done = 1'b0;
            for (int c = 0; c < 64 && !done; c++) begin
                if (dmem_req === 1'b1) nreq++;
                if (c == ack_dly) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
                #1;
                check_eq("stall_req", 32'(stall_o), 32'(c != ack_dly));
                tick();
                dmem_ack   = 1'b0;
                dmem_rdata = $urandom;
                if (c == ack_dly || dmem_req !== 1'b1) done = 1'b1;
            end
            check_eq("req_cycles", 32'(nreq), tmo ? 32'(C_TIMEOUT) : 32'(ack_dly + 1));
            check_eq("req_drop", 32'(dmem_req), 32'd0);
            check_eq("wb_valid_mem", 32'(wb_valid), 32'd1);
            check_eq("mem_error_mem", 32'(mem_error), 32'(tmo));
            check_eq("wb_we_mem", 32'(wb_we), 32'(!tmo && !store && f_regwr && dst != 5'd0));
            if (!tmo && !store) begin
                check_eq("wb_addr_ld", 32'(wb_addr), 32'(dst));
                check_eq("wb_data_ld", wb_data, f_wbsel ? rdata : aligned);
            end
        end

        // Bubble: upstream has consumed the op.
        ex_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; dmem_ack = 1'b0;
        #1;
        check_eq("stall_bubble", 32'(stall_o), 32'd0);
        tick();
        check_eq("wb_valid_bubble", 32'(wb_valid), 32'd0);
        check_eq("wb_we_bubble", 32'(wb_we), 32'd0);
        check_eq("err_cleared", 32'(mem_error), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; alu_res = '0; rd = '0; rt = '0; store_data = '0;
        wb_sel = 1'b0; dst_sel = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; reg_wr = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_wb_we", 32'(wb_we), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_dmem_req", 32'(dmem_req), 32'd0);
        check_eq("rst_mem_error", 32'(mem_error), 32'd0);
        check_eq("rst_stall", 32'(stall_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed cases
        run_op(32'h0000_1234, 5'd5, 5'd9, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h0);
        run_op(32'h0000_0100, 5'd3, 5'd7, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 32'hDEAD_BEEF);
        run_op(32'h0000_0200, 5'd4, 5'd6, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 32'h0);
        run_op(32'h0000_0102, 5'd3, 5'd7, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 32'h0);
        run_op(32'h0000_0300, 5'd3, 5'd8, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, C_NEVER, 32'h0);
        run_op(32'h0000_0404, 5'd3, 5'd8, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 32'h1111_2222);

        // Reset asserted while a request is outstanding
        ex_valid = 1'b1; alu_res = 32'h0000_0500; mem_rd = 1'b1; mem_wr = 1'b0;
        reg_wr = 1'b1; dst_sel = 1'b0; rt = 5'd9; wb_sel = 1'b1; dmem_ack = 1'b0;
        tick();
        tick();
        check_eq("pre_rst_req", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_req", 32'(dmem_req), 32'd0);
        check_eq("midrst_stall", 32'(stall_o), 32'd0);
        check_eq("midrst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("midrst_wb_we", 32'(wb_we), 32'd0);
        ex_valid = 1'b0; mem_rd = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_op(32'h0000_00AB, 5'd0, 5'd4, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h0);
        run_op(32'h0000_00CD, 5'd12, 5'd4, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h0);

        // Randomized ops
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            int          kind, dly;
            logic        f_mrd, f_mwr;
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            kind = int'($urandom_range(0, 3));
            f_mrd = (kind == 1) || (kind == 3);
            f_mwr = (kind == 2) || (kind == 3);
            dly  = ($urandom_range(0, 9) == 0) ? C_NEVER : int'($urandom_range(0, 4));
            run_op(a, 5'($urandom), 5'($urandom), $urandom, 1'($urandom), 1'($urandom),
                   f_mrd, f_mwr, 1'($urandom), dly, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mem_wb_stage
`default_nettype wire
